// File: rtl/dual_crack_ctrl.sv
// ---------------------------------------------------------------------------
// dual_crack_ctrl
//
// Sequencing controller for the two-core ARC4 key search. It copies the
// length-prefixed ciphertext from the shared ciphertext memory into both
// cores' local ciphertext memories, starts both cores together and collects
// the first valid key. Core 0 searches even keys and core 1 searches odd keys,
// so whichever core reports a valid key first owns the answer.
//
// Ports
//   clk           in   system clock, all state on rising edge
//   rst_n         in   asynchronous active-low reset
//   en            in   start request, honoured only while rdy=1
//   rdy           out  controller idle, able to accept en
//   key[23:0]     out  recovered key, meaningful when key_valid=1
//   key_valid     out  last search found a key
//   ct_addr[7:0]  out  shared ciphertext read address (1-cycle read latency)
//   ct_rddata[7:0]in   shared ciphertext read data
//   lct_addr[7:0] out  local ciphertext write address (both cores)
//   lct_wrdata[7:0]out local ciphertext write data
//   lct_wren      out  local ciphertext write enable
//   c0_en, c1_en  out  core start pulses (always together)
//   c0_rdy,c1_rdy in   core idle
//   c0_done,c1_done in core finished pulse
//   c0_key,c1_key in   core result key, qualified by cN_done
//   c0_key_valid,c1_key_valid in core found a key, qualified by cN_done
//   core_abort    out  one-cycle pulse returning both cores to idle
// ---------------------------------------------------------------------------
module dual_crack_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    output logic        rdy,
    output logic [23:0] key,
    output logic        key_valid,
    output logic [7:0]  ct_addr,
    input  logic [7:0]  ct_rddata,
    output logic [7:0]  lct_addr,
    output logic [7:0]  lct_wrdata,
    output logic        lct_wren,
    output logic        c0_en,
    output logic        c1_en,
    input  logic        c0_rdy,
    input  logic        c1_rdy,
    input  logic        c0_done,
    input  logic        c1_done,
    input  logic [23:0] c0_key,
    input  logic [23:0] c1_key,
    input  logic        c0_key_valid,
    input  logic        c1_key_valid,
    output logic        core_abort
);

    localparam int KEY_W  = 24;
    localparam int DATA_W = 8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RDLEN,
        S_COPY,
        S_START,
        S_RUN
    } state_t;

    state_t              state, state_nx;
    logic [DATA_W-1:0]   len_q, len_nx;
    logic [DATA_W-1:0]   idx_q, idx_nx;
    logic                f0_q, f0_nx;
    logic                f1_q, f1_nx;
    logic [KEY_W-1:0]    key_nx;
    logic                key_valid_nx;
    logic                abort_nx;

    // Per-core outcome of a done pulse in the current cycle.
    logic hit0, hit1, miss0, miss1;

    assign hit0  = c0_done &  c0_key_valid;
    assign hit1  = c1_done &  c1_key_valid;
    assign miss0 = c0_done & ~c0_key_valid;
    assign miss1 = c1_done & ~c1_key_valid;

    // State and result registers. Every register is reset so a reset in the
    // middle of a run discards all partial progress.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            len_q      <= '0;
            idx_q      <= '0;
            f0_q       <= 1'b0;
            f1_q       <= 1'b0;
            key        <= '0;
            key_valid  <= 1'b0;
            core_abort <= 1'b0;
        end else begin
            state      <= state_nx;
            len_q      <= len_nx;
            idx_q      <= idx_nx;
            f0_q       <= f0_nx;
            f1_q       <= f1_nx;
            key        <= key_nx;
            key_valid  <= key_valid_nx;
            core_abort <= abort_nx;
        end
    end

    // Next-state and output decode.
    always_comb begin
        state_nx     = state;
        len_nx       = len_q;
        idx_nx       = idx_q;
        f0_nx        = f0_q;
        f1_nx        = f1_q;
        key_nx       = key;
        key_valid_nx = key_valid;
        abort_nx     = 1'b0;
        rdy          = 1'b0;
        ct_addr      = '0;
        lct_addr     = '0;
        lct_wrdata   = '0;
        lct_wren     = 1'b0;
        c0_en        = 1'b0;
        c1_en        = 1'b0;

        case (state)
            S_IDLE: begin
                // ct_addr=0 here so mem[0] (the length) is on ct_rddata in RDLEN.
                rdy = 1'b1;
                if (en) begin
                    key_valid_nx = 1'b0;
                    state_nx     = S_RDLEN;
                end
            end

            S_RDLEN: begin
                len_nx     = ct_rddata;
                lct_wren   = 1'b1;
                lct_addr   = '0;
                lct_wrdata = ct_rddata;
                ct_addr    = 8'd1;
                idx_nx     = 8'd1;
                state_nx   = (ct_rddata == '0) ? S_START : S_COPY;
            end

            S_COPY: begin
                // The read for idx was issued one cycle earlier, so ct_rddata
                // is mem[idx]; issue the read for idx+1 in parallel. The end
                // test precedes the increment, so len=255 never wraps idx.
                lct_wren   = 1'b1;
                lct_addr   = idx_q;
                lct_wrdata = ct_rddata;
                ct_addr    = idx_q + 8'd1;
                if (idx_q == len_q) begin
                    state_nx = S_START;
                end else begin
                    idx_nx = idx_q + 8'd1;
                end
            end

            S_START: begin
                // A core still recovering from an abort simply delays the start.
                if (c0_rdy && c1_rdy) begin
                    c0_en    = 1'b1;
                    c1_en    = 1'b1;
                    f0_nx    = 1'b0;
                    f1_nx    = 1'b0;
                    state_nx = S_RUN;
                end
            end

            S_RUN: begin
                // Valid results take precedence over invalid ones, and core 0
                // takes precedence over core 1.
                if (hit0) begin
                    key_nx       = c0_key;
                    key_valid_nx = 1'b1;
                    abort_nx     = 1'b1;
                    state_nx     = S_IDLE;
                end else if (hit1) begin
                    key_nx       = c1_key;
                    key_valid_nx = 1'b1;
                    abort_nx     = 1'b1;
                    state_nx     = S_IDLE;
                end else begin
                    f0_nx = f0_q | miss0;
                    f1_nx = f1_q | miss1;
                    if ((f0_q | miss0) && (f1_q | miss1)) begin
                        key_valid_nx = 1'b0;
                        state_nx     = S_IDLE;
                    end
                end
            end

            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

endmodule

// File: doc/dual_crack_ctrl.md
# dual_crack_ctrl

Sequencing controller for the two-core ARC4 key search. Owns the shared ciphertext memory read port and copies the message into both cores' local ciphertext memories. It then starts both crack cores with the rdy/en handshake and collects the first valid key, or reports that no key was found. Sits between the top-level task wrapper and two `crack` instances; by construction, core 0 searches even keys and core 1 searches odd keys.

## Interface
- No parameters; key width fixed at 24, addresses and data at 8.
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- en  in  1  start request, sampled only while rdy=1
- rdy  out  1  controller idle and able to accept en
- key  out  24  recovered key, valid when key_valid=1
- key_valid  out  1  last search found a key
- ct_addr  out  8  shared ciphertext memory address (synchronous read, 1-cycle latency)
- ct_rddata  in  8  shared ciphertext memory data
- lct_addr  out  8  local ciphertext write address, broadcast to both cores' memories
- lct_wrdata  out  8  local ciphertext write data
- lct_wren  out  1  local ciphertext write enable
- c0_en, c1_en  out  1  core start pulses
- c0_rdy, c1_rdy  in  1  core idle
- c0_done, c1_done  in  1  core finished pulse, one cycle
- c0_key, c1_key  in  24  core result key, qualified by cN_done
- c0_key_valid, c1_key_valid  in  1  core found a key, qualified by cN_done
- core_abort  out  1  one-cycle pulse forcing both cores back to idle

## Operation
- IDLE: rdy=1, ct_addr=0. On en&rdy, clear key_valid and go to RDLEN. en while rdy=0 is ignored.
- RDLEN, one cycle:
  - ct_rddata = mem[0] = len.
  - Latch len; write lct[0]=len (lct_wren=1, lct_addr=0); drive ct_addr=1; idx=1.
  - If len=0, go to START; otherwise go to COPY.
- COPY, one cycle per byte:
  - Write lct[idx]=ct_rddata; drive ct_addr=idx+1.
  - If idx==len, go to START; otherwise idx++.
  - len=255 is legal. Compare idx==len before incrementing, so there is no wrap.
- START:
  - Wait until c0_rdy&c1_rdy.
  - Then assert c0_en and c1_en together for exactly one cycle and go to RUN.
- RUN: track per-core finished flags f0/f1.
  - cN_done with cN_key_valid=1: latch key=cN_key, set key_valid=1, pulse core_abort the next cycle, return to IDLE.
  - cN_done with cN_key_valid=0: set fN. When f0&f1, set key_valid=0 and return to IDLE.
  - Simultaneous valid done from both cores: core 0 wins.
  - Valid done coinciding with the other core's invalid done: valid wins.
- cN_done outside RUN is ignored.
- key and key_valid hold their values in IDLE until the next accepted en.

## Timing
- Reset values: rdy=1, key=0, key_valid=0, ct_addr=0, lct_addr=0, lct_wrdata=0, lct_wren=0, c0_en=c1_en=0, core_abort=0, state IDLE.
- Reset asserted mid-operation: immediate return to IDLE, all outputs as above, partial results discarded.
- Accepting en at edge k:
  - rdy=0 from k.
  - RDLEN write occurs in cycle k..k+1.
  - Copy finishes after 1+len write cycles.
  - cN_en pulses in the first START cycle in which both cores are ready.
- core_abort asserts in the cycle after RUN exits on a valid key, for one cycle. rdy=1 in that same cycle.
- The next run's START waits for both cN_rdy, so a core still aborting delays the start but is never skipped.
- lct_wren is high on exactly len+1 cycles per run, with addresses 0..len in order.

## Test plan
- Reset, then ct mem [3,0xAA,0xBB,0xCC]; pulse en:
  - lct writes (0,3),(1,AA),(2,BB),(3,CC) on consecutive cycles;
  - then c0_en=c1_en=1 for one cycle;
  - rdy=0 throughout.
- c1_done=1, c1_key_valid=1, c1_key=0x000123 in RUN → key=0x000123, key_valid=1, core_abort pulse one cycle, rdy=1.
- Both done the same cycle, both valid, c0_key=0x10, c1_key=0x11 → key=0x10.
- c0_done invalid, then 20 cycles later c1_done invalid → key_valid=0, rdy=1, no core_abort.
- len=0 → exactly one lct write (0,0), then start. len=255 → 256 writes, last to address 255, no wrap.
- rst_n low during COPY → all outputs at reset values, rdy=1. A new en runs a full copy from address 0.
